// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the barrel-shifter issue/capture logic.
//   - WIDTH / SEL_W : fixed geometry of the 16-lane rotate-right mux array
//   - shift_op_e    : request operation encodings (matches the 2-bit in_op bus)
//   - state_e       : issue controller FSM states
//   - eff_sel()     : maps (op, amount) to the select the array needs
// -----------------------------------------------------------------------------
package shift_pkg;

    // The mux array is a fixed 16x16:1 structure; these are not tunable.
    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        OP_ROR = 2'd0,
        OP_ROL = 2'd1,
        OP_LSR = 2'd2,
        OP_LSL = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // The array only rotates right, so left operations use the 4-bit
    // two's complement of the amount (amount 0 wraps to select 0).
    function automatic logic [SEL_W-1:0] eff_sel(input shift_op_e op,
                                                 input logic [SEL_W-1:0] amt);
        logic [SEL_W-1:0] neg;
        neg = (~amt) + SEL_W'(1);
        if (op == OP_ROL || op == OP_LSL)
            return neg;
        else
            return amt;
    endfunction

endpackage

// File: rtl/shift_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_issue_ctrl_if
// Request and result handshakes of the shift issue controller.
//   request : in_valid, in_ready, in_data[15:0], in_amt[3:0], in_op[1:0]
//   result  : out_valid, out_ready, out_data[15:0]
// Modports:
//   master - the requester/consumer side (drives requests, accepts results)
//   slave  - the controller side
// -----------------------------------------------------------------------------
interface shift_issue_ctrl_if;
    import shift_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_amt;
    logic [1:0]       in_op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_mask_gen.sv
// -----------------------------------------------------------------------------
// shift_mask_gen
// Combinational zero-fill mask applied to the rotated array output.
//   op   in  operation (rotates keep every bit)
//   amt  in  shift amount 0..15 (the raw amount, not the array select)
//   mask out AND mask: LSR clears the top amt bits, LSL the bottom amt bits
// -----------------------------------------------------------------------------
module shift_mask_gen
    import shift_pkg::*;
(
    input  shift_op_e        op,
    input  logic [SEL_W-1:0] amt,
    output logic [WIDTH-1:0] mask
);

    always_comb begin
        mask = '1;
        case (op)
            OP_LSR:  mask = {WIDTH{1'b1}} >> amt;
            OP_LSL:  mask = {WIDTH{1'b1}} << amt;
            default: mask = '1;
        endcase
    end

endmodule

// File: rtl/shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// shift_issue_ctrl
// Issue/capture stage around the 16-lane rotate-right mux array.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   bus        slave modport: request in_* and result out_* handshakes
//   sh_data    out operand to the array data inputs
//   sh_sel     out select to the array (rotate right by sh_sel)
//   sh_result  in  array output
// Parameter:
//   SETTLE_CYCLES  cycles the final select is held before capture (1..15)
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request (in_ready=1 once out of reset)
// LOAD    | operand applied, select driven to eff^1 to force a change
// SETTLE  | select = eff, held SETTLE_CYCLES; capture on the last cycle
// HOLD    | out_valid=1, result held until out_ready
// -----------------------------------------------------------------------------
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    shift_issue_ctrl_if.slave bus,
    output logic [WIDTH-1:0]  sh_data,
    output logic [SEL_W-1:0]  sh_sel,
    input  logic [WIDTH-1:0]  sh_result
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [SEL_W-1:0] amt_q;
    shift_op_e        op_q;
    logic [SEL_W-1:0] eff_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic             load;
    logic             capture;
    shift_op_e        in_op_e;
    logic [SEL_W-1:0] eff_in;
    logic [WIDTH-1:0] mask;

    assign in_op_e = shift_op_e'(bus.in_op);
    assign eff_in  = eff_sel(in_op_e, bus.in_amt);

    shift_mask_gen u_mask (
        .op   (op_q),
        .amt  (amt_q),
        .mask (mask)
    );

    // in_ready_q is also the acceptance qualifier, so the first IDLE cycle
    // after reset release cannot accept a request.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    load    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            amt_q       <= '0;
            op_q        <= OP_ROR;
            eff_q       <= '0;
            sh_data     <= '0;
            sh_sel      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == HOLD);

            if (load) begin
                sh_data <= bus.in_data;
                amt_q   <= bus.in_amt;
                op_q    <= in_op_e;
                eff_q   <= eff_in;
                // The array only re-evaluates on a select edge; stepping
                // through eff^1 guarantees one even for a repeated amount.
                sh_sel  <= eff_in ^ SEL_W'(1);
            end

            if (state_q == LOAD) begin
                sh_sel <= eff_q;
                cnt_q  <= '0;
            end else if (state_q == SETTLE && !capture) begin
                cnt_q  <= cnt_q + 4'd1;
            end

            if (capture)
                out_data_q <= sh_result & mask;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_ctrl
// Directed bench for shift_issue_ctrl with a behavioural 16-lane mux array
// that, like the real one, only re-evaluates when its select changes.
// -----------------------------------------------------------------------------
module tb_shift_issue_ctrl;
    import shift_pkg::*;

    localparam int SC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sh_data;
    logic [3:0]  sh_sel;
    logic [15:0] sh_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_issue_ctrl_if bus ();

    shift_issue_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sh_data   (sh_data),
        .sh_sel    (sh_sel),
        .sh_result (sh_result)
    );

    // Mux array: lane i = data[(i + sel) mod 16], evaluated on select change only.
    always @(sh_sel) begin
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = sh_data[(i + int'(sh_sel)) % 16];
        sh_result = r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits for its result. edges counts clock edges
    // from the acceptance edge (inclusive) until out_valid is seen high.
    task automatic run_req(input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] op, output logic [15:0] res,
                           output int edges, output logic [3:0] sel_load,
                           output logic [3:0] sel_settle, output bit to);
        int n;
        to = 1'b0; res = '0; edges = 0; sel_load = '0; sel_settle = '0;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            to = 1'b1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = op;
        tick();
        bus.in_valid = 1'b0;
        edges    = 1;
        sel_load = sh_sel;
        while (bus.out_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            if (edges == 2) sel_settle = sh_sel;
        end
        if (bus.out_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        res = bus.out_data;
        if (bus.out_ready === 1'b1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_op = '0;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
        total++; if (sh_data !== 16'h0000) begin bad++; $display("FAIL reset_sh_data got=%h want=0000", sh_data); end
        total++; if (sh_sel !== 4'h0) begin bad++; $display("FAIL reset_sh_sel got=%h want=0", sh_sel); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_ror();
        logic [15:0] res; int edges; logic [3:0] sl, ss; bit to;
        run_req(16'h1234, 4'd4, 2'd0, res, edges, sl, ss, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL ror_timeout got=%b want=0", to); end
        total++; if (sl !== 4'd5) begin bad++; $display("FAIL ror_load_sel got=%0d want=5", sl); end
        total++; if (ss !== 4'd4) begin bad++; $display("FAIL ror_settle_sel got=%0d want=4", ss); end
        total++; if (res !== 16'h4123) begin bad++; $display("FAIL ror_data got=%h want=4123", res); end
        total++; if (edges != SC + 2) begin bad++; $display("FAIL ror_latency got=%0d want=%0d", edges, SC + 2); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ror_valid_drop got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_rol();
        logic [15:0] res; int edges; logic [3:0] sl, ss; bit to;
        run_req(16'h8001, 4'd1, 2'd1, res, edges, sl, ss, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rol1_timeout got=%b want=0", to); end
        total++; if (sl !== 4'd14) begin bad++; $display("FAIL rol1_load_sel got=%0d want=14", sl); end
        total++; if (ss !== 4'd15) begin bad++; $display("FAIL rol1_settle_sel got=%0d want=15", ss); end
        total++; if (res !== 16'h0003) begin bad++; $display("FAIL rol1_data got=%h want=0003", res); end
        run_req(16'hBEEF, 4'd0, 2'd1, res, edges, sl, ss, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rol0_timeout got=%b want=0", to); end
        total++; if (ss !== 4'd0) begin bad++; $display("FAIL rol0_settle_sel got=%0d want=0", ss); end
        total++; if (res !== 16'hBEEF) begin bad++; $display("FAIL rol0_data got=%h want=beef", res); end
    endtask

    task automatic test_logical();
        logic [15:0] res; int edges; logic [3:0] sl, ss; bit to;
        run_req(16'hF00F, 4'd4, 2'd2, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'h0F00) begin bad++; $display("FAIL lsr4_data got=%h to=%b want=0f00", res, to); end
        run_req(16'hF00F, 4'd4, 2'd3, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'h00F0) begin bad++; $display("FAIL lsl4_data got=%h to=%b want=00f0", res, to); end
        total++; if (ss !== 4'd12) begin bad++; $display("FAIL lsl4_settle_sel got=%0d want=12", ss); end
        run_req(16'hFFFF, 4'd15, 2'd3, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'h8000) begin bad++; $display("FAIL lsl15_data got=%h to=%b want=8000", res, to); end
        run_req(16'hFFFF, 4'd15, 2'd2, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'h0001) begin bad++; $display("FAIL lsr15_data got=%h to=%b want=0001", res, to); end
        run_req(16'hA5A5, 4'd0, 2'd2, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'hA5A5) begin bad++; $display("FAIL lsr0_data got=%h to=%b want=a5a5", res, to); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r1, r2; int edges; logic [3:0] sl, ss; bit to1, to2;
        run_req(16'h0001, 4'd3, 2'd0, r1, edges, sl, ss, to1);
        run_req(16'h0010, 4'd3, 2'd0, r2, edges, sl, ss, to2);
        total++; if (to1 !== 1'b0 || r1 !== 16'h2000) begin bad++; $display("FAIL b2b_first got=%h to=%b want=2000", r1, to1); end
        total++; if (to2 !== 1'b0 || r2 !== 16'h0002) begin bad++; $display("FAIL b2b_second got=%h to=%b want=0002", r2, to2); end
        total++; if (sl !== 4'd2) begin bad++; $display("FAIL b2b_load_sel got=%0d want=2", sl); end
    endtask

    task automatic test_backpressure();
        logic [15:0] res; int edges; logic [3:0] sl, ss; bit to;
        bus.out_ready = 1'b0;
        run_req(16'hA5C3, 4'd8, 2'd0, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'hC3A5) begin bad++; $display("FAIL bp_data got=%h to=%b want=c3a5", res, to); end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 16'hFFFF;
            bus.in_amt   = 4'd1;
            bus.in_op    = 2'd3;
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hC3A5 ||
                bus.in_ready !== 1'b0 || sh_sel !== 4'd8 || sh_data !== 16'hA5C3) begin
                bad++;
                $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b sel=%0d shd=%h want 1 c3a5 0 8 a5c3",
                         i, bus.out_valid, bus.out_data, bus.in_ready, sh_sel, sh_data);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_ghost got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res; int edges; logic [3:0] sl, ss; bit to;
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_wait got=%b want=1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_amt = 4'd2; bus.in_op = 2'd3;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++; if (sh_sel !== 4'd14) begin bad++; $display("FAIL rm_in_settle_sel got=%0d want=14", sh_sel); end
        rst_n = 1'b0;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.in_ready !== 1'b0 ||
            sh_sel !== 4'd0 || sh_data !== 16'h0000) begin
            bad++;
            $display("FAIL rm_reset got valid=%b data=%h ready=%b sel=%0d shd=%h want 0 0000 0 0 0000",
                     bus.out_valid, bus.out_data, bus.in_ready, sh_sel, sh_data);
        end
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_release got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
        run_req(16'h00F0, 4'd4, 2'd0, res, edges, sl, ss, to);
        total++; if (to !== 1'b0 || res !== 16'h000F) begin bad++; $display("FAIL rm_after_data got=%h to=%b want=000f", res, to); end
        total++; if (edges != SC + 2) begin bad++; $display("FAIL rm_after_latency got=%0d want=%0d", edges, SC + 2); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ror();
        test_rol();
        test_logical();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
